pgm_gfx_mem_arbiter: RTL and testbench

Shares the single 64-bit DDRAM graphics read port between the video fetch engines. Requester 0 is the sprite A-ROM fetch, requester 1 the background tile fetch and requester 2 the text/FG tile fetch. The block sits between those engines and the DDRAM controller. It issues one read at a time, routes the returned 64-bit word back to the owner, and guards against lost responses with a timeout.

---
 rtl/pgm_gfx_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_pgm_gfx_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_gfx_mem_arbiter.sv
// rtl/pgm_gfx_mem_arbiter.sv - single-outstanding DDRAM gfx read arbiter with response timeout
// Optional: define PGM_GFX_ARB_RR_EN for round-robin owner selection (fixed priority otherwise).
module pgm_gfx_mem_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 29,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_grant_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [63:0]               rsp_data_o,
  output logic                      rsp_err_o,
  output logic                      arb_busy_o,
  output logic                      ddram_rd_o,
  output logic [ADDR_W-1:0]         ddram_addr_o,
  input  logic                      ddram_busy_i,
  input  logic [63:0]               ddram_dout_i,
  input  logic                      ddram_dout_ready_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DATA,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 ddram_rd_q, ddram_rd_d;
  logic [ADDR_W-1:0]    ddram_addr_q, ddram_addr_d;
  logic [NUM_REQ-1:0]   req_grant_q, req_grant_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [63:0]          rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [7:0]           cnt_q, cnt_d;

  logic [IDX_W-1:0]     sel_idx;
  logic [ADDR_W-1:0]    sel_addr;
  logic [NUM_REQ-1:0]   owner_oh;

`ifdef PGM_GFX_ARB_RR_EN
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [IDX_W-1:0]     rr_cand;
  logic                 rr_found;

  // Search starts at the pointer and wraps, so the last owner becomes lowest priority.
  always_comb begin
    sel_idx  = '0;
    rr_cand  = '0;
    rr_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_cand = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      if (!rr_found && req_i[rr_cand]) begin
        rr_found = 1'b1;
        sel_idx  = rr_cand;
      end
    end
  end
`else
  always_comb begin
    sel_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) sel_idx = IDX_W'(i);
    end
  end
`endif

  assign sel_addr = req_addr_i[sel_idx*ADDR_W +: ADDR_W];
  assign owner_oh = NUM_REQ'(1) << owner_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      owner_q      <= '0;
      ddram_rd_q   <= 1'b0;
      ddram_addr_q <= '0;
      req_grant_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
`ifdef PGM_GFX_ARB_RR_EN
      rr_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ddram_rd_q   <= ddram_rd_d;
      ddram_addr_q <= ddram_addr_d;
      req_grant_q  <= req_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
`ifdef PGM_GFX_ARB_RR_EN
      rr_q         <= rr_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ddram_rd_d   = ddram_rd_q;
    ddram_addr_d = ddram_addr_q;
    req_grant_d  = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;
`ifdef PGM_GFX_ARB_RR_EN
    rr_d         = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          owner_d      = sel_idx;
          ddram_addr_d = sel_addr;
          ddram_rd_d   = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!ddram_busy_i) begin
          ddram_rd_d  = 1'b0;
          req_grant_d = owner_oh;
          cnt_d       = '0;
`ifdef PGM_GFX_ARB_RR_EN
          rr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
          // A controller that answers in the accept cycle skips WAIT_DATA entirely.
          if (ddram_dout_ready_i) begin
            rsp_data_d  = ddram_dout_i;
            rsp_err_d   = 1'b0;
            rsp_valid_d = owner_oh;
            state_d     = S_RESP;
          end else begin
            state_d = S_WAIT_DATA;
          end
        end
      end
      S_WAIT_DATA: begin
        if (ddram_dout_ready_i) begin
          rsp_data_d  = ddram_dout_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = owner_oh;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == TIMEOUT_LAST) begin
            rsp_data_d  = '0;
            rsp_err_d   = 1'b1;
            rsp_valid_d = owner_oh;
            state_d     = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_grant_o  = req_grant_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign arb_busy_o   = (state_q != S_IDLE);
  assign ddram_rd_o   = ddram_rd_q;
  assign ddram_addr_o = ddram_addr_q;

endmodule

// File: tb/tb_pgm_gfx_mem_arbiter.sv
// tb/tb_pgm_gfx_mem_arbiter.sv - directed scoreboard bench for pgm_gfx_mem_arbiter
module tb_pgm_gfx_mem_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 29;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_grant;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [63:0]               rsp_data;
    logic                      rsp_err;
    logic                      arb_busy;
    logic                      ddram_rd;
    logic [ADDR_W-1:0]         ddram_addr;
    logic                      ddram_busy;
    logic [63:0]               ddram_dout;
    logic                      ddram_dout_ready;

    typedef struct packed {
        logic [2:0]  v;
        logic [63:0] d;
        logic        e;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic keep_req = 1'b0;
    int   rw, sw;

    pgm_gfx_mem_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .TIMEOUT(255)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_i             (req),
        .req_addr_i        (req_addr),
        .req_grant_o       (req_grant),
        .rsp_valid_o       (rsp_valid),
        .rsp_data_o        (rsp_data),
        .rsp_err_o         (rsp_err),
        .arb_busy_o        (arb_busy),
        .ddram_rd_o        (ddram_rd),
        .ddram_addr_o      (ddram_addr),
        .ddram_busy_i      (ddram_busy),
        .ddram_dout_i      (ddram_dout),
        .ddram_dout_ready_i(ddram_dout_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_addr(input int i, input logic [ADDR_W-1:0] a);
        req_addr[i*ADDR_W +: ADDR_W] = a;
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("quiet_rsp_valid", rsp_valid, 3'b000);
        end
    endtask

    task automatic wait_rsp(input int max, output int n);
        exp_t e;
        n = 0;
        while (rsp_valid == 3'b000 && n < max) begin
            step();
            n++;
        end
        chk("rsp_seen", |rsp_valid, 1'b1);
        if (|rsp_valid) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rsp_valid", rsp_valid, e.v);
                chk("rsp_data", rsp_data, e.d);
                chk("rsp_err", rsp_err, e.e);
            end else begin
                chk("unexpected_rsp", rsp_valid, 3'b000);
            end
            if (!keep_req) req = req & ~rsp_valid;
            step();
            chk("rsp_pulse_1cyc", rsp_valid, 3'b000);
        end
    endtask

    task automatic serve(input int idx, input logic [ADDR_W-1:0] addr, input int busy_n,
                         input int lat, input logic [63:0] data, input logic drop,
                         output int rd_wait, output int rsp_wait);
        logic [2:0] oh;
        oh = 3'b001 << idx;
        rd_wait = 0;
        while (!ddram_rd && rd_wait < 20) begin
            step();
            rd_wait++;
        end
        chk("rd_seen", ddram_rd, 1'b1);
        chk("rd_addr", ddram_addr, addr);
        if (busy_n > 0) begin
            ddram_busy = 1'b1;
            for (int i = 1; i <= busy_n; i++) begin
                step();
                chk("busy_rd_hold", ddram_rd, 1'b1);
                chk("busy_addr_hold", ddram_addr, addr);
                chk("busy_no_grant", req_grant, 3'b000);
                if (i == 1 && busy_n >= 3) begin
                    set_addr(idx, ~addr);
                    ddram_dout_ready = 1'b1;
                    ddram_dout       = 64'hDEAD_BEEF_DEAD_BEEF;
                end
                if (i == 2) ddram_dout_ready = 1'b0;
                if (i == busy_n) ddram_busy = 1'b0;
            end
        end
        if (lat == 0) begin
            ddram_dout_ready = 1'b1;
            ddram_dout       = data;
        end
        step();
        chk("grant", req_grant, oh);
        chk("rd_dropped", ddram_rd, 1'b0);
        ddram_dout_ready = 1'b0;
        if (drop) req[idx] = 1'b0;
        if (lat > 0) begin
            for (int j = 1; j < lat; j++) step();
            ddram_dout_ready = 1'b1;
            ddram_dout       = data;
            step();
            ddram_dout_ready = 1'b0;
        end
        wait_rsp(300, rsp_wait);
    endtask

    initial begin
        reset            = 1'b1;
        req              = '0;
        req_addr         = '0;
        ddram_busy       = 1'b0;
        ddram_dout       = '0;
        ddram_dout_ready = 1'b0;
        repeat (3) step();
        chk("rst_rd", ddram_rd, 1'b0);
        chk("rst_addr", ddram_addr, 29'h0);
        chk("rst_grant", req_grant, 3'b000);
        chk("rst_rsp_valid", rsp_valid, 3'b000);
        chk("rst_rsp_data", rsp_data, 64'h0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_busy", arb_busy, 1'b0);
        reset = 1'b0;
        step();

        set_addr(0, 29'h0001000);
        sb.push_back({3'b001, 64'h0123456789ABCDEF, 1'b0});
        req = 3'b001;
        serve(0, 29'h0001000, 0, 4, 64'h0123456789ABCDEF, 1'b0, rw, sw);
        chk("t1_rd_latency", rw, 1);
        chk("t1_rsp_latency", sw, 0);
        step();
        chk("t1_data_hold", rsp_data, 64'h0123456789ABCDEF);

        set_addr(1, 29'h0002000);
        set_addr(2, 29'h0003000);
        sb.push_back({3'b010, 64'h1111_2222_3333_4444, 1'b0});
        sb.push_back({3'b100, 64'h5555_6666_7777_8888, 1'b0});
        req = 3'b110;
        serve(1, 29'h0002000, 0, 2, 64'h1111_2222_3333_4444, 1'b0, rw, sw);
        serve(2, 29'h0003000, 0, 3, 64'h5555_6666_7777_8888, 1'b0, rw, sw);
        chk("t2_issue_gap", rw, 1);

        set_addr(1, 29'h1ABCDEF);
        sb.push_back({3'b010, 64'hCAFE_F00D_0000_0001, 1'b0});
        req = 3'b010;
        serve(1, 29'h1ABCDEF, 10, 1, 64'hCAFE_F00D_0000_0001, 1'b0, rw, sw);

        set_addr(2, 29'h0000777);
        sb.push_back({3'b100, 64'hA5A5_5A5A_A5A5_5A5A, 1'b0});
        req = 3'b100;
        serve(2, 29'h0000777, 0, 0, 64'hA5A5_5A5A_A5A5_5A5A, 1'b0, rw, sw);
        chk("same_cycle_rsp_latency", sw, 0);

        set_addr(0, 29'h0004000);
        sb.push_back({3'b001, 64'h0, 1'b1});
        req = 3'b001;
        serve(0, 29'h0004000, 0, -1, 64'h0, 1'b0, rw, sw);
        chk("timeout_cycles", sw, 255);
        ddram_dout_ready = 1'b1;
        ddram_dout       = 64'hFFFF_0000_FFFF_0000;
        step();
        ddram_dout_ready = 1'b0;
        quiet(4);
        chk("stray_idle_busy", arb_busy, 1'b0);
        chk("stray_err_hold", rsp_err, 1'b1);
        chk("stray_data_hold", rsp_data, 64'h0);

        set_addr(2, 29'h0005000);
        sb.push_back({3'b100, 64'h0BAD_F00D_1234_5678, 1'b0});
        req = 3'b100;
        serve(2, 29'h0005000, 0, 3, 64'h0BAD_F00D_1234_5678, 1'b1, rw, sw);
        chk("drop_idle_busy", arb_busy, 1'b0);
        quiet(3);

        set_addr(0, 29'h0006000);
        req = 3'b001;
        step();
        chk("rw_rd", ddram_rd, 1'b1);
        step();
        chk("rw_grant", req_grant, 3'b001);
        step();
        step();
        reset = 1'b1;
        req   = 3'b000;
        step();
        chk("rw_rst_rd", ddram_rd, 1'b0);
        chk("rw_rst_addr", ddram_addr, 29'h0);
        chk("rw_rst_grant", req_grant, 3'b000);
        chk("rw_rst_rsp_valid", rsp_valid, 3'b000);
        chk("rw_rst_rsp_data", rsp_data, 64'h0);
        chk("rw_rst_busy", arb_busy, 1'b0);
        reset            = 1'b0;
        ddram_dout_ready = 1'b1;
        ddram_dout       = 64'h7777_7777_7777_7777;
        step();
        ddram_dout_ready = 1'b0;
        quiet(4);
        chk("rw_idle_busy", arb_busy, 1'b0);

`ifdef PGM_GFX_ARB_RR_EN
        set_addr(0, 29'h0010000);
        set_addr(1, 29'h0020000);
        set_addr(2, 29'h0030000);
        sb.push_back({3'b001, 64'h0000_0000_0000_00A0, 1'b0});
        sb.push_back({3'b010, 64'h0000_0000_0000_00A1, 1'b0});
        sb.push_back({3'b100, 64'h0000_0000_0000_00A2, 1'b0});
        keep_req = 1'b1;
        req      = 3'b111;
        serve(0, 29'h0010000, 0, 2, 64'h0000_0000_0000_00A0, 1'b0, rw, sw);
        serve(1, 29'h0020000, 0, 2, 64'h0000_0000_0000_00A1, 1'b0, rw, sw);
        keep_req = 1'b0;
        req      = 3'b100;
        serve(2, 29'h0030000, 0, 2, 64'h0000_0000_0000_00A2, 1'b0, rw, sw);
        quiet(3);
`endif

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
